frv_masked_b2a: RTL and testbench
=================================

FRV_MASKED_B2A -- requirements
Module: frv_masked_b2a

Interface
REQ-001 Parameter BIT_WIDTH, default 32, datapath width of every share and randomness port.
REQ-002 g_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 g_reset  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  abort the current conversion; synchronous; same effect as g_reset.
REQ-005 valid  input  1  request: the upstream stage holds it high with stable shares until ready is seen.
REQ-006 b_s0  input  BIT_WIDTH  boolean share 0; x = b_s0 ^ b_s1.
REQ-007 b_s1  input  BIT_WIDTH  boolean share 1 (mask r).
REQ-008 z0  input  BIT_WIDTH  fresh randomness gamma; a new value is supplied every cycle.
REQ-009 a_s0  output  BIT_WIDTH  arithmetic share 0; x = a_s0 + a_s1 mod 2^BIT_WIDTH.
REQ-010 a_s1  output  BIT_WIDTH  arithmetic share 1 (equals the captured r).
REQ-011 ready  output  1  one-cycle pulse: a_s0/a_s1 hold a valid result.

Function
REQ-012 The block SHALL convert the boolean-masked word from the masked add/sub unit into arithmetic shares using Goubin's method, A = ((x'^g)-g) ^ x' ^ ((x'^(r^g))-(r^g)), with x'=b_s0, r=b_s1, g=z0.
REQ-013 The FSM SHALL use exactly the states IDLE, S_MASK, S_SUB, S_COMB and S_DONE.
REQ-014 IDLE with valid=1 and flush=0: accept at edge e0; capture x', r, g and rg=r^g; go to S_MASK.
REQ-015 S_MASK -> S_SUB at e1: register t1=(x'^g)-g and u=x'^rg.
REQ-016 S_SUB -> S_COMB at e2: register acc=t1^x' and t2=u-rg.
REQ-017 S_COMB -> S_DONE at e3: register a_s0=acc^t2 and a_s1=r.
REQ-018 S_DONE -> IDLE at e4 unconditionally; ready=1 only in S_DONE, decoded from the state register (no combinational path from inputs).
REQ-019 Latency SHALL be fixed: ready is high in the cycle after the 4th rising edge counting acceptance as edge 1; minimum issue period is 5 cycles.
REQ-020 Inputs and z0 SHALL be sampled only at acceptance; changes while busy are ignored.
REQ-021 Subtractions SHALL be modulo 2^BIT_WIDTH; wrap-around is discarded silently.
REQ-022 No combinational path SHALL combine x' with r unmasked; every intermediate is registered between stages.
REQ-023 a_s0/a_s1 SHALL hold the last result until the next S_COMB->S_DONE transition, flush or reset.
REQ-024 valid=1 while busy or in S_DONE SHALL start no new conversion; acceptance occurs only in IDLE.
REQ-025 flush in any state SHALL win over valid: next state IDLE, ready=0, and no acceptance that cycle.

Reset
REQ-026 On g_reset=1 or flush=1 at a rising edge: state=IDLE, ready=0, a_s0=0, a_s1=0, and all intermediate registers (x', r, g, rg, t1, u, acc, t2) are cleared to 0.
REQ-027 Reset or flush mid-conversion SHALL discard the operation; no ready pulse follows it.

Structure
REQ-028 The state enum and BIT_WIDTH default SHALL live in the shared package frv_masked_pkg.
REQ-029 Sub-module frv_masked_b2a_sub (BIT_WIDTH modular subtractor) SHALL be instantiated twice, one per subtraction; no subtractor is time-shared between share-dependent operands.
REQ-030 The RTL SHALL contain no other hierarchy.

Verification
REQ-031 b_s0=0x000000FF, b_s1=0x0000000F, z0=0x12345678, valid held high -> ready 4 edges after acceptance; a_s1=0x0000000F; a_s0=0x000000E1.
REQ-032 b_s0=0xDEADBEEF, b_s1=0, random z0 -> a_s0=0xDEADBEEF, a_s1=0.
REQ-033 b_s0=1, b_s1=1 (x=0) -> a_s0=0xFFFFFFFF, a_s1=1 (wrap).
REQ-034 flush=1 in S_SUB -> ready stays 0 and outputs are 0 on the next cycle; a new request afterwards completes correctly.
REQ-035 valid held high continuously, 1000 random shares with z0 randomized every cycle -> ready pulses every 5 cycles; a_s0+a_s1 == b_s0^b_s1 at each pulse; no X.
REQ-036 Inputs changed during S_MASK..S_COMB -> the result matches the values captured at acceptance.

Source files
------------

// File: rtl/frv_masked_pkg.sv
// ---------------------------------------------------------------------------
// frv_masked_pkg
//   Shared definitions for the masked conversion blocks.
//   - DEFAULT_BIT_WIDTH : default datapath width for every share and the
//                         randomness port.
//   - b2a_state_t       : state encoding of the boolean-to-arithmetic
//                         conversion FSM.
// ---------------------------------------------------------------------------
package frv_masked_pkg;

    localparam int unsigned DEFAULT_BIT_WIDTH = 32;

    // One state per register stage of Goubin's conversion, plus the
    // idle and result-valid states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_MASK = 3'd1,
        S_SUB  = 3'd2,
        S_COMB = 3'd3,
        S_DONE = 3'd4
    } b2a_state_t;

endpackage

// File: rtl/frv_masked_b2a_sub.sv
// ---------------------------------------------------------------------------
// frv_masked_b2a_sub
//   Modular subtractor used by the boolean-to-arithmetic converter.
//   difference = minuend - subtrahend mod 2^BIT_WIDTH; the borrow out of the
//   top bit is discarded.
//   Ports:
//     minuend    [BIT_WIDTH-1:0]  in   left operand
//     subtrahend [BIT_WIDTH-1:0]  in   right operand
//     difference [BIT_WIDTH-1:0]  out  wrapped difference
// ---------------------------------------------------------------------------
module frv_masked_b2a_sub
    import frv_masked_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] minuend,
    input  logic [BIT_WIDTH-1:0] subtrahend,
    output logic [BIT_WIDTH-1:0] difference
);

    assign difference = minuend - subtrahend;

endmodule

// File: rtl/frv_masked_b2a.sv
// ---------------------------------------------------------------------------
// frv_masked_b2a
//   Converts a boolean-masked word (x = b_s0 ^ b_s1) into arithmetic shares
//   (x = a_s0 + a_s1 mod 2^BIT_WIDTH) with Goubin's method:
//     A = ((x'^g)-g) ^ x' ^ ((x'^(r^g))-(r^g)),  x'=b_s0, r=b_s1, g=z0
//   The computation is spread over four register stages so that x' and r
//   never meet unmasked in one combinational cloud. Fixed latency: ready
//   pulses for one cycle after the fourth rising edge counting acceptance.
//   Ports:
//     g_clk    in   clock, rising edge
//     g_reset  in   synchronous active-high reset
//     flush    in   synchronous abort, same effect as g_reset
//     valid    in   request, shares held stable until ready
//     b_s0     in   boolean share 0 (x')
//     b_s1     in   boolean share 1 (mask r)
//     z0       in   fresh randomness gamma, sampled at acceptance only
//     a_s0     out  arithmetic share 0
//     a_s1     out  arithmetic share 1 (captured r)
//     ready    out  one-cycle result-valid pulse
// ---------------------------------------------------------------------------
module frv_masked_b2a
    import frv_masked_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 flush,
    input  logic                 valid,
    input  logic [BIT_WIDTH-1:0] b_s0,
    input  logic [BIT_WIDTH-1:0] b_s1,
    input  logic [BIT_WIDTH-1:0] z0,
    output logic [BIT_WIDTH-1:0] a_s0,
    output logic [BIT_WIDTH-1:0] a_s1,
    output logic                 ready
);

    b2a_state_t state;
    b2a_state_t next_state;

    logic clear;
    logic accept;

    // Captured operands and per-stage intermediates.
    logic [BIT_WIDTH-1:0] x_p;
    logic [BIT_WIDTH-1:0] mask_r;
    logic [BIT_WIDTH-1:0] gamma;
    logic [BIT_WIDTH-1:0] mask_rg;
    logic [BIT_WIDTH-1:0] t1;
    logic [BIT_WIDTH-1:0] u;
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] t2;

    logic [BIT_WIDTH-1:0] sub0_diff;
    logic [BIT_WIDTH-1:0] sub1_diff;

    // Flush behaves exactly like reset, so both collapse into one clear.
    assign clear = g_reset | flush;

    // Each subtraction gets its own subtractor: (x'^g)-g in S_MASK and
    // u-(r^g) in S_SUB never share hardware.
    frv_masked_b2a_sub #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_sub_mask (
        .minuend    (x_p ^ gamma),
        .subtrahend (gamma),
        .difference (sub0_diff)
    );

    frv_masked_b2a_sub #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_sub_comb (
        .minuend    (u),
        .subtrahend (mask_rg),
        .difference (sub1_diff)
    );

    // State register.
    always_ff @(posedge g_clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. ready depends only on the state
    // register, so there is no input-to-ready combinational path.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (valid && !flush) begin
                    accept     = 1'b1;
                    next_state = S_MASK;
                end
            end
            S_MASK:  next_state = S_SUB;
            S_SUB:   next_state = S_COMB;
            S_COMB:  next_state = S_DONE;
            S_DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath pipeline. Every stage writes only its own registers, and all
    // registers hold their value between stages so the outputs persist
    // until the next result, flush or reset.
    always_ff @(posedge g_clk) begin
        if (clear) begin
            x_p     <= '0;
            mask_r  <= '0;
            gamma   <= '0;
            mask_rg <= '0;
            t1      <= '0;
            u       <= '0;
            acc     <= '0;
            t2      <= '0;
            a_s0    <= '0;
            a_s1    <= '0;
        end else begin
            if (accept) begin
                x_p     <= b_s0;
                mask_r  <= b_s1;
                gamma   <= z0;
                mask_rg <= b_s1 ^ z0;
            end
            if (state == S_MASK) begin
                t1 <= sub0_diff;
                u  <= x_p ^ mask_rg;
            end
            if (state == S_SUB) begin
                acc <= t1 ^ x_p;
                t2  <= sub1_diff;
            end
            if (state == S_COMB) begin
                a_s0 <= acc ^ t2;
                a_s1 <= mask_r;
            end
        end
    end

endmodule

// File: tb/tb_frv_masked_b2a.sv
// ---------------------------------------------------------------------------
// tb_frv_masked_b2a
//   Directed self-checking bench for frv_masked_b2a: reset state, hand-worked
//   conversions, wrap-around, flush/reset aborts, input changes while busy
//   and a back-to-back stream of random shares.
// ---------------------------------------------------------------------------
module tb_frv_masked_b2a;

    logic        g_clk;
    logic        g_reset;
    logic        flush;
    logic        valid;
    logic [31:0] b_s0;
    logic [31:0] b_s1;
    logic [31:0] z0;
    logic [31:0] a_s0;
    logic [31:0] a_s1;
    logic        ready;

    int n_assert;
    int n_fail;

    frv_masked_b2a #(
        .BIT_WIDTH (32)
    ) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .flush   (flush),
        .valid   (valid),
        .b_s0    (b_s0),
        .b_s1    (b_s1),
        .z0      (z0),
        .a_s0    (a_s0),
        .a_s1    (a_s1),
        .ready   (ready)
    );

    // 10 time-unit clock.
    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    // Advance one rising edge and settle just after it; randomness is
    // refreshed every cycle as the real source would.
    task automatic tick();
        @(posedge g_clk);
        #1;
        z0 = $urandom;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_ready,
                               input logic [31:0] exp_a0, input logic [31:0] exp_a1);
        checkValue({tag, "_ready"}, {31'b0, ready}, {31'b0, exp_ready});
        checkValue({tag, "_a_s0"}, a_s0, exp_a0);
        checkValue({tag, "_a_s1"}, a_s1, exp_a1);
    endtask

    task automatic checkReady(input string tag, input logic exp_ready);
        checkValue({tag, "_ready"}, {31'b0, ready}, {31'b0, exp_ready});
    endtask

    task automatic applyStimulus(input logic [31:0] s0, input logic [31:0] s1,
                                 input logic [31:0] g, input logic v);
        b_s0  = s0;
        b_s1  = s1;
        z0    = g;
        valid = v;
    endtask

    // One isolated conversion: request for a single edge, optionally
    // scramble the inputs while busy, check ready timing and the result.
    task automatic runDirected(input string tag, input logic [31:0] s0,
                               input logic [31:0] s1, input logic [31:0] g,
                               input logic [31:0] exp_a0, input logic [31:0] exp_a1,
                               input bit scramble);
        applyStimulus(s0, s1, g, 1'b1);
        tick();
        valid = 1'b0;
        if (scramble) begin
            b_s0 = ~s0;
            b_s1 = s1 ^ 32'h5555_AAAA;
        end
        checkReady({tag, "_e1"}, 1'b0);
        tick();
        if (scramble) begin
            b_s0  = $urandom;
            b_s1  = $urandom;
            valid = 1'b1;
        end
        checkReady({tag, "_e2"}, 1'b0);
        tick();
        checkReady({tag, "_e3"}, 1'b0);
        tick();
        checkOutput({tag, "_done"}, 1'b1, exp_a0, exp_a1);
        valid = 1'b0;
        tick();
        checkOutput({tag, "_hold"}, 1'b0, exp_a0, exp_a1);
    endtask

    initial begin
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] sum;

        n_assert = 0;
        n_fail   = 0;
        g_reset  = 1'b1;
        flush    = 1'b0;
        applyStimulus(32'h0, 32'h0, 32'h0, 1'b0);

        tick();
        tick();
        g_reset = 1'b0;
        checkOutput("reset", 1'b0, 32'h0, 32'h0);

        // x = 0xF0, r = 0x0F -> A = 0xE1
        runDirected("vec_ff_0f", 32'h0000_00FF, 32'h0000_000F, 32'h1234_5678,
                    32'h0000_00E1, 32'h0000_000F, 1'b0);
        // Zero mask leaves the value unchanged.
        runDirected("vec_zero_mask", 32'hDEAD_BEEF, 32'h0, $urandom,
                    32'hDEAD_BEEF, 32'h0, 1'b0);
        // x = 0, r = 1 -> A wraps to all ones.
        runDirected("vec_wrap", 32'h1, 32'h1, $urandom,
                    32'hFFFF_FFFF, 32'h1, 1'b0);
        // x = 0x10, r = 0x20 -> A = 0x10 - 0x20, inputs scrambled while busy.
        runDirected("vec_scramble", 32'h0000_0030, 32'h0000_0020, 32'hCAFE_F00D,
                    32'hFFFF_FFF0, 32'h0000_0020, 1'b1);

        // Flush while in S_SUB: outputs cleared, no ready afterwards.
        applyStimulus(32'h0000_00FF, 32'h0000_000F, 32'h1234_5678, 1'b1);
        tick();
        valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_sub", 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkReady("flush_sub_after", 1'b0);
        end
        // x = 0x5A5AA5A5, r = 0xFFFF -> A = 0x5A59A5A6
        runDirected("after_flush", 32'h5A5A_5A5A, 32'h0000_FFFF, $urandom,
                    32'h5A59_A5A6, 32'h0000_FFFF, 1'b0);

        // Flush in IDLE beats a simultaneous request.
        applyStimulus(32'h0000_00FF, 32'h0000_000F, 32'h1234_5678, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        checkOutput("flush_idle", 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkReady("flush_idle_after", 1'b0);
        end

        // Reset in S_COMB discards the conversion.
        applyStimulus(32'h0000_00FF, 32'h0000_000F, 32'h1234_5678, 1'b1);
        tick();
        valid = 1'b0;
        tick();
        tick();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        checkOutput("reset_comb", 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkReady("reset_comb_after", 1'b0);
        end

        // Back-to-back stream with valid held high: one result every 5 cycles.
        s0 = $urandom;
        s1 = $urandom;
        applyStimulus(s0, s1, $urandom, 1'b1);
        for (int k = 0; k < 1000; k++) begin
            tick();
            checkReady("stream_e1", 1'b0);
            tick();
            checkReady("stream_e2", 1'b0);
            tick();
            checkReady("stream_e3", 1'b0);
            tick();
            checkReady("stream_done", 1'b1);
            sum = a_s0 + a_s1;
            checkValue("stream_sum", sum, s0 ^ s1);
            checkValue("stream_a_s1", a_s1, s1);
            checkValue("stream_noX", {31'b0, $isunknown({a_s0, a_s1, ready})}, 32'h0);
            s0   = $urandom;
            s1   = $urandom;
            b_s0 = s0;
            b_s1 = s1;
            tick();
            checkReady("stream_idle", 1'b0);
        end
        valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
